// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable and run control.
// All outputs are registered and decoded from the next raster position, so they never skew.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               ce,
    input  logic               run,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic               video_on_q, video_on_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    // Raster successor of the current position, valid while running.
    logic [CNT_W-1:0]   x_nxt, y_nxt;
    logic               frame_wrap;

    // Position to be loaded this edge, and whether a load happens at all.
    logic               load;
    logic [CNT_W-1:0]   px, py;

    function automatic logic in_active(input logic [CNT_W-1:0] xv, input logic [CNT_W-1:0] yv);
        return (int'(xv) < H_ACTIVE) && (int'(yv) < V_ACTIVE);
    endfunction

    function automatic logic in_hsync(input logic [CNT_W-1:0] xv);
        return (int'(xv) >= HS_START) && (int'(xv) < HS_END);
    endfunction

    function automatic logic in_vsync(input logic [CNT_W-1:0] yv);
        return (int'(yv) >= VS_START) && (int'(yv) < VS_END);
    endfunction

    always_comb begin
        x_nxt      = x_q + 1'b1;
        y_nxt      = y_q;
        frame_wrap = 1'b0;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            if (y_q == V_LAST) begin
                y_nxt      = '0;
                frame_wrap = 1'b1;
            end else begin
                y_nxt = y_q + 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        load          = 1'b0;
        px            = '0;
        py            = '0;

        if (!run) begin
            state_d    = IDLE;
            x_d        = '0;
            y_d        = '0;
            video_on_d = 1'b0;
            hsync_d    = ~HS_POL;
            vsync_d    = ~VS_POL;
        end else if (ce) begin
            unique case (state_q)
                IDLE: begin
                    state_d       = RUN;
                    load          = 1'b1;
                    line_start_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
                RUN: begin
                    load          = 1'b1;
                    px            = x_nxt;
                    py            = y_nxt;
                    line_start_d  = (x_nxt == '0);
                    frame_start_d = frame_wrap;
                    if (frame_wrap) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Decodes come from the position being loaded, keeping them aligned with x/y.
        if (load) begin
            x_d        = px;
            y_d        = py;
            video_on_d = in_active(px, py);
            hsync_d    = in_hsync(px) ? HS_POL : ~HS_POL;
            vsync_d    = in_vsync(py) ? VS_POL : ~VS_POL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
